// File: rtl/mii_frame_tx_if.sv
// Byte-stream handshake between the BRAM/UART source and the MII transmit framer.
// A byte moves on a mainclk edge where s_valid and s_ready are both high.
interface mii_frame_tx_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/mii_frame_tx.sv
// MII transmit framer: preamble/SFD, payload, zero padding, CRC-32 FCS and inter-frame gap,
// one nibble per nib_en strobe, fed from a one-byte holding register.
module mii_frame_tx #(
  parameter int MIN_FRAME   = 60,
  parameter int MAX_FRAME   = 1514,
  parameter int IFG_NIBBLES = 24
) (
  input  logic         mainclk,
  input  logic         rst,
  input  logic         nib_en,
  mii_frame_tx_if.slave strm,
  output logic         eth_tx_en,
  output logic [3:0]   eth_txd,
  output logic         busy,
  output logic         frame_done,
  output logic         tx_abort
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam int          PRE_NIBBLES = 16;
  localparam int          PRE_W       = $clog2(PRE_NIBBLES);
  localparam int          IFG_W       = (IFG_NIBBLES > 1) ? $clog2(IFG_NIBBLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  state_t             state_reg,      state_next;
  logic [7:0]         hold_reg,       hold_next;
  logic               hold_last_reg,  hold_last_next;
  logic               hold_valid_reg, hold_valid_next;
  logic               last_taken_reg, last_taken_next;
  logic [3:0]         hi_nib_reg,     hi_nib_next;
  logic               cur_last_reg,   cur_last_next;
  logic               nib_hi_reg,     nib_hi_next;
  logic [31:0]        crc_reg,        crc_next;
  logic [10:0]        byte_cnt_reg,   byte_cnt_next;
  logic [PRE_W-1:0]   pre_cnt_reg,    pre_cnt_next;
  logic [2:0]         fcs_cnt_reg,    fcs_cnt_next;
  logic [IFG_W-1:0]   ifg_cnt_reg,    ifg_cnt_next;
  logic               tx_en_reg,      tx_en_next;
  logic [3:0]         txd_reg,        txd_next;
  logic               done_reg,       done_next;
  logic               abort_reg,      abort_next;

  logic               s_ready_int;
  logic               accept;
  logic [7:0]         crc_byte;
  logic [31:0]        crc_step [9];
  logic [3:0]         fcs_nibs [8];

  // A byte is only taken when the holding register is empty and the frame's last byte has not been seen.
  assign s_ready_int = ~hold_valid_reg & ~last_taken_reg & ~rst;
  assign strm.s_ready = s_ready_int;
  assign accept = strm.s_valid & s_ready_int;

  // Byte-wide reflected CRC: eight unrolled LSB-first bit steps; pad bytes feed zeros.
  assign crc_byte    = (state_reg == ST_DATA) ? hold_reg : 8'h00;
  assign crc_step[0] = crc_reg ^ {24'd0, crc_byte};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_crc
      assign crc_step[gi+1] = crc_step[gi][0] ? ((crc_step[gi] >> 1) ^ CRC_POLY)
                                              : (crc_step[gi] >> 1);
    end
  endgenerate

  generate
    for (gi = 0; gi < 8; gi++) begin : g_fcs
      assign fcs_nibs[gi] = ~crc_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge mainclk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      hold_reg       <= 8'h00;
      hold_last_reg  <= 1'b0;
      hold_valid_reg <= 1'b0;
      last_taken_reg <= 1'b0;
      hi_nib_reg     <= 4'h0;
      cur_last_reg   <= 1'b0;
      nib_hi_reg     <= 1'b0;
      crc_reg        <= CRC_INIT;
      byte_cnt_reg   <= 11'd0;
      pre_cnt_reg    <= '0;
      fcs_cnt_reg    <= 3'd0;
      ifg_cnt_reg    <= '0;
      tx_en_reg      <= 1'b0;
      txd_reg        <= 4'h0;
      done_reg       <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_reg       <= hold_next;
      hold_last_reg  <= hold_last_next;
      hold_valid_reg <= hold_valid_next;
      last_taken_reg <= last_taken_next;
      hi_nib_reg     <= hi_nib_next;
      cur_last_reg   <= cur_last_next;
      nib_hi_reg     <= nib_hi_next;
      crc_reg        <= crc_next;
      byte_cnt_reg   <= byte_cnt_next;
      pre_cnt_reg    <= pre_cnt_next;
      fcs_cnt_reg    <= fcs_cnt_next;
      ifg_cnt_reg    <= ifg_cnt_next;
      tx_en_reg      <= tx_en_next;
      txd_reg        <= txd_next;
      done_reg       <= done_next;
      abort_reg      <= abort_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hold_next       = hold_reg;
    hold_last_next  = hold_last_reg;
    hold_valid_next = hold_valid_reg;
    last_taken_next = last_taken_reg;
    hi_nib_next     = hi_nib_reg;
    cur_last_next   = cur_last_reg;
    nib_hi_next     = nib_hi_reg;
    crc_next        = crc_reg;
    byte_cnt_next   = byte_cnt_reg;
    pre_cnt_next    = pre_cnt_reg;
    fcs_cnt_next    = fcs_cnt_reg;
    ifg_cnt_next    = ifg_cnt_reg;
    tx_en_next      = tx_en_reg;
    txd_next        = txd_reg;
    done_next       = 1'b0;
    abort_next      = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (nib_en && hold_valid_reg) begin
          state_next   = ST_PREAMBLE;
          tx_en_next   = 1'b1;
          txd_next     = 4'h5;
          pre_cnt_next = PRE_W'(1);
        end
      end

      ST_PREAMBLE: begin
        if (nib_en) begin
          if (pre_cnt_reg == PRE_W'(PRE_NIBBLES - 1)) begin
            txd_next    = 4'hD;
            nib_hi_next = 1'b0;
            state_next  = ST_DATA;
          end else begin
            txd_next     = 4'h5;
            pre_cnt_next = pre_cnt_reg + PRE_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (nib_en) begin
          if (nib_hi_reg) begin
            txd_next    = hi_nib_reg;
            nib_hi_next = 1'b0;
            if (cur_last_reg) begin
              fcs_cnt_next = 3'd0;
              state_next   = (int'(byte_cnt_reg) < MIN_FRAME) ? ST_PAD : ST_FCS;
            end
          end else if (!hold_valid_reg || int'(byte_cnt_reg) >= MAX_FRAME) begin
            // Underrun or oversize: drop tx_en immediately and discard any byte still held.
            tx_en_next      = 1'b0;
            txd_next        = 4'h0;
            abort_next      = 1'b1;
            hold_valid_next = 1'b0;
            ifg_cnt_next    = '0;
            state_next      = ST_IFG;
          end else begin
            txd_next        = hold_reg[3:0];
            hi_nib_next     = hold_reg[7:4];
            cur_last_next   = hold_last_reg;
            hold_valid_next = 1'b0;
            crc_next        = crc_step[8];
            byte_cnt_next   = byte_cnt_reg + 11'd1;
            nib_hi_next     = 1'b1;
          end
        end
      end

      ST_PAD: begin
        if (nib_en) begin
          txd_next = 4'h0;
          if (!nib_hi_reg) begin
            crc_next      = crc_step[8];
            byte_cnt_next = byte_cnt_reg + 11'd1;
            nib_hi_next   = 1'b1;
          end else begin
            nib_hi_next = 1'b0;
            if (int'(byte_cnt_reg) >= MIN_FRAME) begin
              fcs_cnt_next = 3'd0;
              state_next   = ST_FCS;
            end
          end
        end
      end

      ST_FCS: begin
        if (nib_en) begin
          txd_next     = fcs_nibs[fcs_cnt_reg];
          fcs_cnt_next = fcs_cnt_reg + 3'd1;
          if (fcs_cnt_reg == 3'd7) begin
            done_next    = 1'b1;
            ifg_cnt_next = '0;
            state_next   = ST_IFG;
          end
        end
      end

      ST_IFG: begin
        if (nib_en) begin
          tx_en_next   = 1'b0;
          txd_next     = 4'h0;
          ifg_cnt_next = ifg_cnt_reg + IFG_W'(1);
          if (ifg_cnt_reg == IFG_W'(IFG_NIBBLES - 1)) begin
            last_taken_next = 1'b0;
            crc_next        = CRC_INIT;
            byte_cnt_next   = 11'd0;
            state_next      = ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // Evaluated last so a byte (and its last flag) taken on the final IFG cycle is kept.
    if (accept) begin
      hold_next       = strm.s_data;
      hold_last_next  = strm.s_last;
      hold_valid_next = 1'b1;
      if (strm.s_last) begin
        last_taken_next = 1'b1;
      end
    end
  end

  assign eth_tx_en  = tx_en_reg;
  assign eth_txd    = txd_reg;
  assign frame_done = done_reg;
  assign tx_abort   = abort_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mii_frame_tx.sv
// Bench for mii_frame_tx: randomized byte streams checked slot by slot against a frame-level model
// (preamble, payload, pad, CRC, IFG), with two DUT instances for the two parameter sets.
module tb_mii_frame_tx;
  localparam int IFG = 24;

  typedef logic [7:0] byte_q_t[$];
  // Expected slot entry: {tx_en, txd[3:0], frame_done, tx_abort, end_of_ifg}
  typedef logic [7:0] ent_t;

  logic mainclk;
  logic rst;
  logic nib_en;
  logic sel;
  logic [7:0] src_data;
  logic src_valid;
  logic src_last;

  mii_frame_tx_if if_a ();
  mii_frame_tx_if if_b ();

  logic en_a, en_b, busy_a, busy_b, done_a, done_b, ab_a, ab_b;
  logic [3:0] txd_a, txd_b;

  assign if_a.s_data  = src_data;
  assign if_a.s_last  = src_last;
  assign if_a.s_valid = src_valid & ~sel;
  assign if_b.s_data  = src_data;
  assign if_b.s_last  = src_last;
  assign if_b.s_valid = src_valid & sel;

  mii_frame_tx dut_a (
    .mainclk(mainclk), .rst(rst), .nib_en(nib_en), .strm(if_a),
    .eth_tx_en(en_a), .eth_txd(txd_a), .busy(busy_a), .frame_done(done_a), .tx_abort(ab_a)
  );

  mii_frame_tx #(.MIN_FRAME(0), .MAX_FRAME(64), .IFG_NIBBLES(IFG)) dut_b (
    .mainclk(mainclk), .rst(rst), .nib_en(nib_en), .strm(if_b),
    .eth_tx_en(en_b), .eth_txd(txd_b), .busy(busy_b), .frame_done(done_b), .tx_abort(ab_b)
  );

  logic obs_en, obs_busy, obs_done, obs_ab, obs_ready;
  logic [3:0] obs_txd;
  assign obs_en    = sel ? en_b : en_a;
  assign obs_txd   = sel ? txd_b : txd_a;
  assign obs_busy  = sel ? busy_b : busy_a;
  assign obs_done  = sel ? done_b : done_a;
  assign obs_ab    = sel ? ab_b : ab_a;
  assign obs_ready = sel ? if_b.s_ready : if_a.s_ready;

  int total = 0;
  int bad = 0;
  ent_t exp_q[$];
  bit aligned = 0;
  int slot_idx = 0;
  int en_slots, done_cnt, abort_cnt, zero_run, last_gap;

  initial begin
    mainclk = 1'b0;
    forever #5 mainclk = ~mainclk;
  end

  initial begin
    int nc;
    nc = 0;
    nib_en = 1'b0;
    forever begin
      @(posedge mainclk);
      #1;
      nc = (nc + 1) % 4;
      nib_en = (nc == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] crc32_of(input byte_q_t q, input int n);
    logic [31:0] c;
    logic [7:0] b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = 8'h00;
      if (i < q.size()) b = q[i];
      c = c ^ {24'd0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Appends the slot sequence one frame must produce; abort_at >= 0 means abort when byte abort_at+1 is due.
  task automatic push_frame(input byte_q_t q, input int min_len, input int abort_at);
    logic [31:0] fcs;
    logic [7:0] b;
    int tlen;
    for (int i = 0; i < 15; i++) exp_q.push_back({1'b1, 4'h5, 3'b000});
    exp_q.push_back({1'b1, 4'hD, 3'b000});
    if (abort_at >= 0) begin
      for (int i = 0; i < abort_at; i++) begin
        b = q[i];
        exp_q.push_back({1'b1, b[3:0], 3'b000});
        exp_q.push_back({1'b1, b[7:4], 3'b000});
      end
      exp_q.push_back({1'b0, 4'h0, 3'b010});
    end else begin
      tlen = (q.size() > min_len) ? q.size() : min_len;
      for (int i = 0; i < tlen; i++) begin
        b = 8'h00;
        if (i < q.size()) b = q[i];
        exp_q.push_back({1'b1, b[3:0], 3'b000});
        exp_q.push_back({1'b1, b[7:4], 3'b000});
      end
      fcs = ~crc32_of(q, tlen);
      for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, fcs[4*k +: 4], (k == 7), 2'b00});
    end
    for (int k = 0; k < IFG; k++) exp_q.push_back({1'b0, 4'h0, 2'b00, (k == IFG - 1)});
  endtask

  // Compare process: every cycle out of reset, outputs are checked against the model.
  initial begin
    logic slot, at_rst, prev_en;
    logic [3:0] prev_txd;
    ent_t e;
    prev_en = 1'b0;
    prev_txd = 4'h0;
    forever begin
      @(posedge mainclk);
      slot = nib_en;
      at_rst = rst;
      #1;
      if (!at_rst) begin
        if (!slot) begin
          chk("en_hold", obs_en, prev_en);
          chk("txd_hold", obs_txd, prev_txd);
          chk("done_between_slots", obs_done, 1'b0);
          chk("abort_between_slots", obs_ab, 1'b0);
        end else begin
          if (!aligned && exp_q.size() > 0 && obs_en) begin
            aligned = 1;
            slot_idx = 0;
          end
          if (aligned) begin
            e = exp_q.pop_front();
            slot_idx++;
            chk("slot_tx_en", obs_en, e[7]);
            chk("slot_txd", obs_txd, e[6:3]);
            chk("slot_frame_done", obs_done, e[2]);
            chk("slot_tx_abort", obs_ab, e[1]);
            chk("slot_busy", obs_busy, !e[0]);
            if (exp_q.size() == 0) aligned = 0;
          end else begin
            chk("idle_tx_en", obs_en, 1'b0);
            chk("idle_busy", obs_busy, 1'b0);
            chk("idle_done", obs_done, 1'b0);
            chk("idle_abort", obs_ab, 1'b0);
          end
          if (obs_en) begin
            en_slots++;
            if (zero_run > 0) last_gap = zero_run;
            zero_run = 0;
          end else begin
            zero_run++;
          end
          if (obs_done) done_cnt++;
          if (obs_ab) abort_cnt++;
        end
      end
      prev_en = obs_en;
      prev_txd = obs_txd;
    end
  end

  task automatic clear_stats();
    en_slots = 0;
    done_cnt = 0;
    abort_cnt = 0;
    zero_run = 0;
    last_gap = -1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input int dly);
    int n;
    logic acc;
    src_valid = 1'b0;
    repeat (dly) begin
      @(posedge mainclk);
      #1;
    end
    src_data = d;
    src_last = l;
    src_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 3000) begin
      @(negedge mainclk);
      acc = obs_ready;
      @(posedge mainclk);
      #1;
      n++;
    end
    src_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no s_ready, want byte %0h accepted", d);
    end
  endtask

  task automatic send_range(input byte_q_t q, input int first, input int last_idx, input int maxdly);
    for (int i = first; i <= last_idx; i++) send_byte(q[i], (i == q.size() - 1), $urandom_range(maxdly, 0));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || aligned) && n < budget) begin
      @(posedge mainclk);
      #2;
      n++;
    end
    total++;
    if (exp_q.size() > 0 || aligned) begin
      bad++;
      $display("FAIL drain_timeout: got %0d slots pending, want 0", exp_q.size());
      exp_q.delete();
      aligned = 0;
    end
  endtask

  task automatic rand_payload(output byte_q_t q, input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    byte_q_t q, q2;
    int n;
    rst = 1'b1;
    sel = 1'b0;
    src_valid = 1'b0;
    src_data = 8'h00;
    src_last = 1'b0;
    clear_stats();
    repeat (5) @(posedge mainclk);
    #2;
    chk("rst_tx_en", obs_en, 1'b0);
    chk("rst_txd", obs_txd, 4'h0);
    chk("rst_busy", obs_busy, 1'b0);
    chk("rst_s_ready", obs_ready, 1'b0);
    chk("rst_done", obs_done, 1'b0);
    chk("rst_abort", obs_ab, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", obs_ready, 1'b1);

    // 1: "123456789", no padding
    sel = 1'b1;
    clear_stats();
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    chk("model_crc_check_value", ~crc32_of(q, 9), 32'hCBF43926);
    push_frame(q, 0, -1);
    send_range(q, 0, 8, 2);
    wait_drain(4000);
    chk("t1_en_slots", en_slots, 42);
    chk("t1_done_count", done_cnt, 1);
    $display("test 1 crc check string: en_slots=%0d done=%0d abort=%0d", en_slots, done_cnt, abort_cnt);

    // 2: single byte 0xAA padded to 60
    sel = 1'b0;
    clear_stats();
    q.delete();
    q.push_back(8'hAA);
    push_frame(q, 60, -1);
    send_range(q, 0, 0, 2);
    wait_drain(4000);
    chk("t2_en_slots", en_slots, 144);
    chk("t2_done_count", done_cnt, 1);
    $display("test 2 one-byte padded: en_slots=%0d done=%0d abort=%0d", en_slots, done_cnt, abort_cnt);

    // 3: two back-to-back 60-byte frames, s_valid held
    clear_stats();
    rand_payload(q, 60);
    rand_payload(q2, 60);
    push_frame(q, 60, -1);
    push_frame(q2, 60, -1);
    send_range(q, 0, 59, 0);
    send_range(q2, 0, 59, 0);
    wait_drain(8000);
    chk("t3_ifg_gap", last_gap, IFG);
    chk("t3_en_slots", en_slots, 288);
    chk("t3_done_count", done_cnt, 2);
    $display("test 3 back-to-back: gap=%0d en_slots=%0d done=%0d", last_gap, en_slots, done_cnt);

    // 4: underrun after byte 10; the remaining bytes form the next frame
    clear_stats();
    rand_payload(q, 60);
    q2.delete();
    for (int i = 10; i < 60; i++) q2.push_back(q[i]);
    push_frame(q, 60, 10);
    push_frame(q2, 60, -1);
    send_range(q, 0, 9, 2);
    n = 0;
    while (!obs_ready && n < 200) begin
      @(posedge mainclk);
      #1;
      n++;
    end
    chk("t4_hold_freed", obs_ready, 1'b1);
    repeat (12) @(posedge mainclk);
    #1;
    send_range(q, 10, 59, 2);
    wait_drain(8000);
    chk("t4_abort_count", abort_cnt, 1);
    chk("t4_done_count", done_cnt, 1);
    chk("t4_en_slots", en_slots, 36 + 144);
    $display("test 4 underrun: en_slots=%0d done=%0d abort=%0d", en_slots, done_cnt, abort_cnt);

    // 5: reset during FCS nibble 3, then a clean frame
    clear_stats();
    rand_payload(q, 60);
    push_frame(q, 60, -1);
    send_range(q, 0, 59, 2);
    n = 0;
    while (!(aligned && slot_idx == 139) && n < 4000) begin
      @(posedge mainclk);
      #2;
      n++;
    end
    chk("t5_reached_fcs3", slot_idx, 139);
    rst = 1'b1;
    exp_q.delete();
    aligned = 0;
    @(posedge mainclk);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_tx_en", obs_en, 1'b0);
    chk("t5_rst_busy", obs_busy, 1'b0);
    chk("t5_rst_s_ready", obs_ready, 1'b1);
    clear_stats();
    rand_payload(q, 60);
    push_frame(q, 60, -1);
    send_range(q, 0, 59, 2);
    wait_drain(4000);
    chk("t5_en_slots", en_slots, 144);
    chk("t5_done_count", done_cnt, 1);
    $display("test 5 reset mid-fcs: en_slots=%0d done=%0d abort=%0d", en_slots, done_cnt, abort_cnt);

    // 6: MAX_FRAME=64 with a 70-byte stream; byte 65 is dropped, 66..70 form the next frame
    sel = 1'b1;
    clear_stats();
    rand_payload(q, 70);
    q2.delete();
    for (int i = 65; i < 70; i++) q2.push_back(q[i]);
    push_frame(q, 0, 64);
    push_frame(q2, 0, -1);
    send_range(q, 0, 69, 2);
    wait_drain(8000);
    chk("t6_abort_count", abort_cnt, 1);
    chk("t6_done_count", done_cnt, 1);
    chk("t6_en_slots", en_slots, 144 + 34);
    $display("test 6 oversize: en_slots=%0d done=%0d abort=%0d", en_slots, done_cnt, abort_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mii_frame_tx.md
Name: mii_frame_tx

Overview:
- MII transmit framer, the transmit-side counterpart of the Ethernet receive path. Consumes a byte stream (valid/ready/last) from the BRAM/UART side.
- Emits a complete Ethernet frame on eth_tx_en/eth_txd: preamble, SFD, payload, zero padding, CRC-32 FCS, then enforced inter-frame gap.
- Runs on mainclk. Nibble timing comes from nib_en, a one-cycle strobe derived externally from a synchronized eth_tx_clk rising edge.

Parameters:
- MIN_FRAME, 60, minimum bytes before FCS; shorter frames are zero-padded to this length (0 disables padding).
- MAX_FRAME, 1514, maximum payload bytes before FCS; exceeding it aborts the frame.
- IFG_NIBBLES, 24, idle nibble slots after each frame or abort.

Ports:
- mainclk  input  1  system clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- nib_en  input  1  one-cycle strobe per MII nibble slot (25 MHz rate)
- s_data  input  8  payload byte
- s_valid  input  1  s_data valid
- s_last  input  1  marks final payload byte; qualified by s_valid
- s_ready  output  1  block accepts a byte this cycle
- eth_tx_en  output  1  MII transmit enable
- eth_txd  output  4  MII transmit nibble
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse after the last FCS nibble is driven
- tx_abort  output  1  one-cycle pulse on underrun or oversize abort

Behaviour:
- Reset (rst on any mainclk edge, including mid-frame):
  - state=IDLE; eth_tx_en=0, eth_txd=0, s_ready=0, busy=0, frame_done=0, tx_abort=0.
  - Holding register emptied; CRC=0xFFFFFFFF; all counters 0.
  - No partial nibble is emitted after a reset.
- Input holding register:
  - One byte (hold, hold_last, hold_valid).
  - s_ready = ~hold_valid & ~last_taken & ~rst, where last_taken is set by accepting s_last and cleared on return to IDLE.
  - Accept when s_valid & s_ready. Accepted bytes are never dropped except on abort or reset.
- Output timing:
  - eth_tx_en and eth_txd are registered and change only on mainclk cycles with nib_en=1. They hold their value between strobes.
- Nibble order: low nibble first, then high nibble, for every byte including SFD and FCS.
- State IDLE:
  - On nib_en with hold_valid=1, go to PREAMBLE, drive the first 0x5, and set eth_tx_en=1.
  - Latency is 1 nib_en slot after a byte is held.
- State PREAMBLE:
  - 15 nibbles of 0x5, then the 16th nibble 0xD (SFD 0xD5 = 0x5, 0xD). Then go to DATA.
- State DATA:
  - At each low-nibble slot, hold_valid must be 1. The byte is moved to the shift register and hold is freed (s_ready may rise the next cycle). CRC is updated with the byte and byte_cnt is incremented.
  - After the high nibble of a byte with hold_last=1: go to PAD if byte_cnt<MIN_FRAME, else to FCS.
  - Underrun: low-nibble slot with hold_valid=0 -> eth_tx_en=0 on that slot, pulse tx_abort, go to IFG.
  - Oversize: byte_cnt would exceed MAX_FRAME -> same abort action as underrun.
- State PAD:
  - Emit 0x00 bytes (two 0x0 nibbles each), CRC-updated, until byte_cnt==MIN_FRAME. Then go to FCS.
- State FCS:
  - Transmit ~CRC as 8 nibbles, least-significant nibble first (bits [3:0], [7:4], …, [31:28]).
  - After the 8th nibble, pulse frame_done and go to IFG.
- State IFG:
  - eth_tx_en=0, eth_txd=0 for IFG_NIBBLES slots, then return to IDLE. Clear last_taken, reset CRC to 0xFFFFFFFF, set byte_cnt=0.
  - A byte may be accepted into hold during IFG only after last_taken clears. The next frame therefore starts no earlier than the first IDLE nib_en.
- CRC:
  - IEEE 802.3 reflected, poly 0xEDB88320, init 0xFFFFFFFF.
  - Byte-wide update (8 unrolled bit steps, LSB first), computed in one mainclk cycle.
  - Covers payload and pad bytes only.
- Widths:
  - byte_cnt is 11 bits and is compared against MAX_FRAME before incrementing, so it never wraps.
  - Preamble and IFG counters are sized by $clog2 of their maxima.
- Simultaneous events:
  - rst overrides everything.
  - Accept and free of hold in the same cycle is impossible by construction, because s_ready requires hold empty.
  - nib_en with s_valid rising in the same cycle in IDLE: the byte is accepted this cycle; the frame starts on the next nib_en.

Test Plan:
- MIN_FRAME=0, payload "123456789" (0x31..0x39), nib_en every 4 cycles:
  - eth_txd shows 15×0x5, then 0xD, then 1,3,2,3…9,3.
  - FCS nibbles are 6,2,9,3,4,F,B,C (CRC 0xCBF43926).
  - tx_en is high for exactly 42 slots; frame_done pulses once.
- Default params, 1-byte payload 0xAA:
  - 59 zero pad bytes follow.
  - 16+120+8=144 tx_en slots; the FCS matches a software model of 0xAA followed by 59×0x00.
- Two back-to-back 60-byte frames with s_valid held high:
  - Exactly 24 tx_en=0 slots between the last FCS nibble and the next preamble.
  - No byte is lost; the second FCS is correct.
- s_valid dropped after byte 10 for 3 slots:
  - tx_abort pulses at the byte-11 low-nibble slot; tx_en falls on that slot.
  - IFG of 24 slots follows; frame_done never pulses.
- rst asserted during FCS nibble 3:
  - Next cycle: tx_en=0, busy=0, s_ready=1.
  - A following 60-byte frame transmits with a correct FCS.
- MAX_FRAME=64, 70-byte stream: tx_abort pulses when the 65th byte is due; no FCS is emitted.
